conv1_ifmap_feeder: RTL and testbench

- Producer side of the conv-layer-1 PE array interface.
- Accepts a raster pixel stream (column-major, 8-bit) and weight words over valid/ready.
- Assembles 26-pixel columns and drives Ifmap_shift_in, en and Filtr_in_2/1/0 toward the 4-kernel PE array.
- Flags which array cycles carry valid Psum_out columns and signals end of frame.

---
 rtl/conv1_ifmap_feeder.sv | 115 +++++++++++
 tb/tb_conv1_ifmap_feeder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/conv1_ifmap_feeder.sv
// conv1_ifmap_feeder: assembles pixel columns and weights for the conv1 PE array; CONV1_COL_PAD_EN adds zero border columns
module conv1_ifmap_feeder #(
    parameter int ROWS   = 26,
    parameter int DW     = 8,
    parameter int COLS   = 26,
    parameter int KW     = 3,
    parameter int PE_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               wt_reload,
    input  logic               wt_valid,
    output logic               wt_ready,
    input  logic [47:0]        wt_data,
    input  logic               px_valid,
    output logic               px_ready,
    input  logic [DW-1:0]      px_data,
    output logic [ROWS*DW-1:0] Ifmap_shift_in,
    output logic [47:0]        Filtr_in_0,
    output logic [47:0]        Filtr_in_1,
    output logic [47:0]        Filtr_in_2,
    output logic               en,
    output logic               psum_valid,
    output logic               busy,
    output logic               frame_done
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = 9;

    typedef enum logic [2:0] {IDLE, WLOAD, FILL, ISSUE, DRAIN} state_t;

    state_t                  r_state, w_next, w_after_load;
    logic [RW-1:0]           r_row;
    logic [CW-1:0]           r_col;
    logic [1:0]              r_wcnt;
    logic [3:0]              r_dcnt;
    logic [(ROWS-1)*DW-1:0]  r_stage;
    logic [ROWS*DW-1:0]      r_ifmap;
    logic [47:0]             r_f0, r_f1, r_f2;
    logic [PE_LAT-1:0]       r_pipe;
    logic                    w_px_hs, w_wt_hs, w_last_col, w_pad_next, w_tag;

`ifdef CONV1_COL_PAD_EN
    localparam int NCOLS = COLS + 2;
    assign w_after_load = ISSUE;
    assign w_pad_next   = r_col == CW'(NCOLS - 2);
`else
    localparam int NCOLS = COLS;
    assign w_after_load = FILL;
    assign w_pad_next   = 1'b0;
`endif

    assign wt_ready       = r_state == WLOAD;
    assign px_ready       = r_state == FILL;
    assign en             = r_state == ISSUE;
    assign busy           = r_state != IDLE;
    assign frame_done     = r_state == DRAIN && r_dcnt == 4'(PE_LAT - 1);
    assign w_wt_hs        = wt_valid & wt_ready;
    assign w_px_hs        = px_valid & px_ready;
    assign w_last_col     = r_col == CW'(NCOLS - 1);
    assign w_tag          = en && r_col >= CW'(KW - 1);
    assign psum_valid     = r_pipe[PE_LAT-1];
    assign Ifmap_shift_in = r_ifmap;
    assign Filtr_in_0     = r_f0;
    assign Filtr_in_1     = r_f1;
    assign Filtr_in_2     = r_f2;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next-state: ISSUE always lasts one cycle; padded columns chain ISSUE to ISSUE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = wt_reload ? WLOAD : w_after_load;
            WLOAD:   if (w_wt_hs && r_wcnt == 2'd2) w_next = w_after_load;
            FILL:    if (w_px_hs && r_row == RW'(ROWS - 1)) w_next = ISSUE;
            ISSUE:   w_next = w_last_col ? DRAIN : w_pad_next ? ISSUE : FILL;
            DRAIN:   if (r_dcnt == 4'(PE_LAT - 1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // datapath: staging rows, issued column, weights, counters and psum latency pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row   <= '0;
            r_col   <= '0;
            r_wcnt  <= '0;
            r_dcnt  <= '0;
            r_stage <= '0;
            r_ifmap <= '0;
            r_f0    <= '0;
            r_f1    <= '0;
            r_f2    <= '0;
            r_pipe  <= '0;
        end else begin
            if (w_px_hs && r_row != RW'(ROWS - 1)) r_stage[r_row*DW +: DW] <= px_data;
            r_row <= w_px_hs ? (r_row == RW'(ROWS - 1) ? '0 : r_row + 1'b1) : r_row;
            if (w_next == ISSUE) r_ifmap <= (r_state == FILL) ? {px_data, r_stage} : '0;
            if (w_next == IDLE) r_col <= '0;
            else if (en) r_col <= r_col + 1'b1;
            r_dcnt <= (r_state == DRAIN) ? r_dcnt + 1'b1 : '0;
            r_wcnt <= w_wt_hs ? (r_wcnt == 2'd2 ? '0 : r_wcnt + 1'b1) : r_wcnt;
            if (w_wt_hs && r_wcnt == 2'd0) r_f0 <= wt_data;
            if (w_wt_hs && r_wcnt == 2'd1) r_f1 <= wt_data;
            if (w_wt_hs && r_wcnt == 2'd2) r_f2 <= wt_data;
            r_pipe <= PE_LAT'({r_pipe, w_tag});
        end
    end
endmodule

// File: tb/tb_conv1_ifmap_feeder.sv
// tb_conv1_ifmap_feeder: randomized stream bench with a column/psum timing model of the feeder
module tb_conv1_ifmap_feeder;
    localparam int ROWS = 26, DW = 8, COLS = 26, KW = 3, PE_LAT = 2, W = ROWS*DW;
`ifdef CONV1_COL_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif
    localparam int NCOLS = PAD ? COLS + 2 : COLS;

    logic clk, rst, start, wt_reload, wt_valid, wt_ready, px_valid, px_ready;
    logic [47:0] wt_data, Filtr_in_0, Filtr_in_1, Filtr_in_2;
    logic [DW-1:0] px_data;
    logic [W-1:0] Ifmap_shift_in;
    logic en, psum_valid, busy, frame_done;

    conv1_ifmap_feeder dut (
        .clk(clk), .rst(rst), .start(start), .wt_reload(wt_reload),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data),
        .Ifmap_shift_in(Ifmap_shift_in), .Filtr_in_0(Filtr_in_0),
        .Filtr_in_1(Filtr_in_1), .Filtr_in_2(Filtr_in_2), .en(en),
        .psum_valid(psum_valid), .busy(busy), .frame_done(frame_done)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;
    logic [DW-1:0] px_q[$], pix_buf[$];
    logic [47:0] wt_q[$];
    logic [47:0] f_exp[3];
    logic [W-1:0] col_q[$];
    int col_cyc_q[$], psum_due[$];
    int wi = 0, hs_cnt = 0, gap_pct = 0, en_idx = 0, en_total = 0, pv_cnt = 0, done_due = -1;
    int data_en_n = 0, first_en_cyc = 0, second_en_cyc = 0, en_snap;
    bit hold = 0, m_data, m_exp_pv, m_exp_fd;
    logic [W-1:0] col_tmp, first_col, m_ec, snap;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // stimulus driver and accepted-data model: pixels grouped into columns, weights in load order
    initial begin
        px_valid = 0; px_data = 0; wt_valid = 0; wt_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                px_valid = 0; wt_valid = 0;
            end else begin
                px_valid = px_q.size() > 0 && !hold && ($urandom_range(99) >= gap_pct);
                px_data = px_q.size() > 0 ? px_q[0] : '0;
                if (px_valid && px_ready) begin
                    pix_buf.push_back(px_q.pop_front());
                    hs_cnt++;
                    if (pix_buf.size() == ROWS) begin
                        for (int r = 0; r < ROWS; r++) col_tmp[r*DW +: DW] = pix_buf[r];
                        col_q.push_back(col_tmp);
                        col_cyc_q.push_back(cyc);
                        pix_buf.delete();
                    end
                end
                wt_valid = wt_q.size() > 0;
                wt_data = wt_valid ? wt_q[0] : '0;
                if (wt_valid && wt_ready) begin
                    f_exp[wi] = wt_q.pop_front();
                    wi = (wi + 1) % 3;
                end
            end
        end
    end

    // output monitor: column contents, issue latency, psum_valid and frame_done timing
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst) begin
            if (en) begin
                m_data = !(PAD && (en_idx == 0 || en_idx == NCOLS - 1));
                if (!m_data) check("pad_col", Ifmap_shift_in, '0);
                else if (col_q.size() == 0) check("col_avail", col_q.size(), 1);
                else begin
                    m_ec = col_q.pop_front();
                    check("col_data", Ifmap_shift_in, m_ec);
                    check("en_latency", cyc, col_cyc_q.pop_front() + 1);
                    if (data_en_n == 0) begin first_en_cyc = cyc; first_col = Ifmap_shift_in; end
                    if (data_en_n == 1) second_en_cyc = cyc;
                    data_en_n++;
                end
                if (en_idx >= KW - 1) psum_due.push_back(cyc + PE_LAT);
                if (en_idx == NCOLS - 1) done_due = cyc + PE_LAT;
                en_idx++;
                en_total++;
            end
            m_exp_pv = psum_due.size() > 0 && psum_due[0] == cyc;
            if (m_exp_pv) void'(psum_due.pop_front());
            if (psum_valid) pv_cnt++;
            if (psum_valid || m_exp_pv) check("psum_valid", psum_valid, m_exp_pv);
            m_exp_fd = done_due == cyc;
            if (frame_done || m_exp_fd) check("frame_done", frame_done, m_exp_fd);
        end
    end

    task automatic pulse_start(input bit r);
        @(negedge clk);
        start = 1; wt_reload = r;
        @(negedge clk);
        start = 0; wt_reload = 0;
    endtask

    task automatic wait_hs(input int n);
        for (int t = 0; t < 5000 && hs_cnt < n; t++) begin
            @(posedge clk);
            #2;
        end
        check("hs_reach", hs_cnt, n);
    endtask

    task automatic begin_frame(input int gap, input int mode);
        gap_pct = gap; en_idx = 0; pv_cnt = 0; hs_cnt = 0; data_en_n = 0; done_due = -1;
        for (int i = 0; i < COLS*ROWS; i++)
            px_q.push_back(mode == 1 && i < ROWS ? DW'(i + 1) : DW'($urandom));
    endtask

    task automatic run_frame(input bit reload, input int gap, input int mode);
        begin_frame(gap, mode);
        if (reload) begin
            if (mode == 1) begin
                wt_q.push_back(48'h111111111111);
                wt_q.push_back(48'h222222222222);
                wt_q.push_back(48'h333333333333);
            end else
                for (int i = 0; i < 3; i++) wt_q.push_back({16'($urandom), 32'($urandom)});
        end
        pulse_start(reload);
        if (mode == 1) begin
            for (int t = 0; t < 100 && wt_q.size() > 0; t++) @(negedge clk);
            @(posedge clk);
            #1;
            check("wt_ready_drop", {wt_ready, px_ready}, 2'b01);
            check("filt0", Filtr_in_0, 48'h111111111111);
            check("filt1", Filtr_in_1, 48'h222222222222);
            check("filt2", Filtr_in_2, 48'h333333333333);
        end
        if (mode == 2) begin
            wait_hs(4*ROWS + 10);
            hold = 1;
            snap = Ifmap_shift_in;
            en_snap = en_total;
            repeat (20) @(negedge clk);
            pulse_start(1);
            repeat (28) @(negedge clk);
            check("stall_no_en", en_total, en_snap);
            check("stall_hold", Ifmap_shift_in, snap);
            check("stall_state", {busy, px_ready, wt_ready}, 3'b110);
            hold = 0;
        end
        for (int t = 0; t < 20000 && !frame_done; t++) @(negedge clk);
        check("done_seen", frame_done, 1);
        @(negedge clk);
        check("busy_after", busy, 0);
        check("en_count", en_idx, NCOLS);
        check("psum_count", pv_cnt, NCOLS - (KW - 1));
        check("filters", {Filtr_in_2, Filtr_in_1, Filtr_in_0}, {f_exp[2], f_exp[1], f_exp[0]});
        if (mode == 1) begin
            check("first_px", first_col[7:0], 8'h01);
            check("last_px", first_col[W-1:W-8], 8'h1A);
            check("col_period", second_en_cyc - first_en_cyc, ROWS + 1);
        end
    endtask

    initial begin
        rst = 1; start = 0; wt_reload = 0;
        for (int i = 0; i < 3; i++) f_exp[i] = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {en, psum_valid, frame_done, busy, px_ready, wt_ready}, 6'b0);
        check("rst_ifmap", Ifmap_shift_in, '0);
        check("rst_filt", {Filtr_in_2, Filtr_in_1, Filtr_in_0}, '0);
        rst = 0;
        run_frame(1, 0, 1);
        run_frame(0, 30, 2);
        begin_frame(0, 0);
        pulse_start(0);
        wait_hs(4*ROWS + 10);
        hold = 1;
        rst = 1;
        #1;
        check("mid_rst_ctrl", {en, psum_valid, frame_done, busy, px_ready, wt_ready}, 6'b0);
        check("mid_rst_ifmap", Ifmap_shift_in, '0);
        check("mid_rst_filt", {Filtr_in_2, Filtr_in_1, Filtr_in_0}, '0);
        px_q.delete(); pix_buf.delete(); col_q.delete(); col_cyc_q.delete(); psum_due.delete();
        for (int i = 0; i < 3; i++) f_exp[i] = '0;
        wi = 0; done_due = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 0; hold = 0;
        run_frame(0, 20, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
